// File: rtl/fp_normalize_pipe.sv
// Leading-zero-detect and normalise pipeline between the FP align/add stage and
// the round/pack stage. Optional split LZC adds a stage that records per-byte
// zero counts; the final stage combines them, picks the shift and shifts.
module fp_normalize_pipe #(
  parameter int LANES       = 16,
  parameter int SIG_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int SPLIT_LZC   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_mode,
  input  logic [LANES-1:0]             in_mask,
  input  logic [LANES*SIG_WIDTH-1:0]   in_sig,
  input  logic [LANES*SHIFT_WIDTH-1:0] in_shift_ovr,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_mask,
  output logic [LANES*SIG_WIDTH-1:0]   out_sig,
  output logic [LANES*SHIFT_WIDTH-1:0] out_shift,
  output logic [LANES-1:0]             out_is_zero,
  output logic [TAG_WIDTH-1:0]         out_tag
);

  localparam int NG = SIG_WIDTH / 8;

  // Leading zeroes in one byte, 0..8
  function automatic logic [3:0] byte_lzc(input logic [7:0] b);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found) begin
        if (b[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  logic [LANES-1:0][NG-1:0][3:0] in_gcnt;
  logic [LANES-1:0][NG-1:0]      in_gzero;

  logic                          f_valid;
  logic [1:0]                    f_mode;
  logic [LANES-1:0]              f_mask;
  logic [LANES*SIG_WIDTH-1:0]    f_sig;
  logic [LANES*SHIFT_WIDTH-1:0]  f_ovr;
  logic [TAG_WIDTH-1:0]          f_tag;
  logic [LANES-1:0][NG-1:0][3:0] f_gcnt;
  logic [LANES-1:0][NG-1:0]      f_gzero;

  logic                          b_ok;
  logic [LANES*SIG_WIDTH-1:0]    nxt_sig;
  logic [LANES*SHIFT_WIDTH-1:0]  nxt_shift;
  logic [LANES-1:0]              nxt_zero;

  // The output stage can take a new beat when empty or when its beat leaves now
  assign b_ok = !out_valid || out_ready;

  // Per-byte-group zero counts and all-zero flags of the incoming significands
  always_comb begin
    in_gcnt  = '0;
    in_gzero = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int g = 0; g < NG; g++) begin
        in_gcnt[l][g]  = byte_lzc(in_sig[l*SIG_WIDTH + g*8 +: 8]);
        in_gzero[l][g] = (in_sig[l*SIG_WIDTH + g*8 +: 8] == 8'd0);
      end
    end
  end

  generate
    if (SPLIT_LZC != 0) begin : g_split
      logic                          a_valid;
      logic [1:0]                    a_mode;
      logic [LANES-1:0]              a_mask;
      logic [LANES*SIG_WIDTH-1:0]    a_sig;
      logic [LANES*SHIFT_WIDTH-1:0]  a_ovr;
      logic [TAG_WIDTH-1:0]          a_tag;
      logic [LANES-1:0][NG-1:0][3:0] a_gcnt;
      logic [LANES-1:0][NG-1:0]      a_gzero;

      // Stage A holds the raw beat plus group counts; loads when empty or draining
      always_ff @(posedge clk) begin
        if (reset) begin
          a_valid <= 1'b0;
          a_mode  <= '0;
          a_mask  <= '0;
          a_sig   <= '0;
          a_ovr   <= '0;
          a_tag   <= '0;
          a_gcnt  <= '0;
          a_gzero <= '0;
        end else if (!a_valid || b_ok) begin
          a_valid <= in_valid;
          if (in_valid) begin
            a_mode  <= in_mode;
            a_mask  <= in_mask;
            a_sig   <= in_sig;
            a_ovr   <= in_shift_ovr;
            a_tag   <= in_tag;
            a_gcnt  <= in_gcnt;
            a_gzero <= in_gzero;
          end
        end
      end

      assign f_valid  = a_valid;
      assign f_mode   = a_mode;
      assign f_mask   = a_mask;
      assign f_sig    = a_sig;
      assign f_ovr    = a_ovr;
      assign f_tag    = a_tag;
      assign f_gcnt   = a_gcnt;
      assign f_gzero  = a_gzero;
      assign in_ready = !reset && (!a_valid || b_ok);
    end else begin : g_flat
      assign f_valid  = in_valid;
      assign f_mode   = in_mode;
      assign f_mask   = in_mask;
      assign f_sig    = in_sig;
      assign f_ovr    = in_shift_ovr;
      assign f_tag    = in_tag;
      assign f_gcnt   = in_gcnt;
      assign f_gzero  = in_gzero;
      assign in_ready = !reset && b_ok;
    end
  endgenerate

  // Combine group counts into a full LZC, select the shift and normalise each lane
  always_comb begin
    nxt_sig   = '0;
    nxt_shift = '0;
    nxt_zero  = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [SIG_WIDTH-1:0]   sig;
      logic [SHIFT_WIDTH-1:0] lzc;
      logic [SHIFT_WIDTH-1:0] sh;
      logic                   found;
      sig   = f_sig[l*SIG_WIDTH +: SIG_WIDTH];
      lzc   = '0;
      sh    = '0;
      found = 1'b0;
      for (int g = NG - 1; g >= 0; g--) begin
        if (!found) begin
          lzc   = lzc + SHIFT_WIDTH'(f_gcnt[l][g]);
          found = !f_gzero[l][g];
        end
      end
      case (f_mode)
        2'd0:    sh = lzc;
        2'd1:    sh = f_ovr[l*SHIFT_WIDTH +: SHIFT_WIDTH];
        default: sh = '0;
      endcase
      if (f_mask[l]) begin
        nxt_shift[l*SHIFT_WIDTH +: SHIFT_WIDTH] = sh;
        nxt_sig[l*SIG_WIDTH +: SIG_WIDTH]       = (int'(sh) >= SIG_WIDTH) ? '0 : (sig << sh);
        nxt_zero[l]                             = (sig == '0);
      end
    end
  end

  // Output stage register; holds its beat while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_mask    <= '0;
      out_sig     <= '0;
      out_shift   <= '0;
      out_is_zero <= '0;
      out_tag     <= '0;
    end else if (b_ok) begin
      out_valid <= f_valid;
      if (f_valid) begin
        out_mask    <= f_mask;
        out_sig     <= nxt_sig;
        out_shift   <= nxt_shift;
        out_is_zero <= nxt_zero;
        out_tag     <= f_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed self-checking bench for fp_normalize_pipe (16 lanes x 32 bits, split LZC).
module tb_fp_normalize_pipe;

   localparam int LANES = 16;
   localparam int SW    = 32;
   localparam int SHW   = 6;
   localparam int TW    = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_mode;
   logic [LANES-1:0]      in_mask;
   logic [LANES*SW-1:0]   in_sig;
   logic [LANES*SHW-1:0]  in_shift_ovr;
   logic [TW-1:0]         in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES-1:0]      out_mask;
   logic [LANES*SW-1:0]   out_sig;
   logic [LANES*SHW-1:0]  out_shift;
   logic [LANES-1:0]      out_is_zero;
   logic [TW-1:0]         out_tag;

   int checks = 0;
   int errors = 0;

   int                  next_tag;
   int                  exp_tag;
   logic                stall_seen;
   logic                prev_stall;
   logic                do_in;
   logic [TW-1:0]       held_tag;
   logic [LANES*SW-1:0] held_sig;
   logic [31:0]         bp_val;
   logic [1:0]          mix_mode;

   fp_normalize_pipe #(
      .LANES(LANES), .SIG_WIDTH(SW), .SHIFT_WIDTH(SHW), .TAG_WIDTH(TW), .SPLIT_LZC(1)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_mask(in_mask),
      .in_sig(in_sig), .in_shift_ovr(in_shift_ovr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
      .out_sig(out_sig), .out_shift(out_shift), .out_is_zero(out_is_zero), .out_tag(out_tag)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Global timeout so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   // Expected significand vector: v in every enabled lane, zero elsewhere
   function automatic logic [LANES*SW-1:0] expSig(input logic [31:0] v, input logic [LANES-1:0] m);
      logic [LANES*SW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++) if (m[l]) r[l*SW +: SW] = v;
      return r;
   endfunction

   // Expected shift vector: s in every enabled lane, zero elsewhere
   function automatic logic [LANES*SHW-1:0] expShift(input logic [5:0] s, input logic [LANES-1:0] m);
      logic [LANES*SHW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++) if (m[l]) r[l*SHW +: SHW] = s;
      return r;
   endfunction

   // Advance past the next rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one beat with the same significand / override in every lane, then settle
   task automatic applyStimulus(input logic v, input logic [1:0] mode, input logic [LANES-1:0] m,
                                input logic [31:0] sig, input logic [5:0] ovr, input logic [TW-1:0] tag);
      in_valid     = v;
      in_mode      = mode;
      in_mask      = m;
      in_sig       = {LANES{sig}};
      in_shift_ovr = {LANES{ovr}};
      in_tag       = tag;
      #1;
   endtask

   // One comparison point
   task automatic checkOutput(input string name, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Send a lone beat and wait until it reaches the output (latency 2)
   task automatic runBeat(input logic [1:0] mode, input logic [31:0] sig, input logic [5:0] ovr,
                          input logic [TW-1:0] tag);
      applyStimulus(1'b1, mode, 16'hFFFF, sig, ovr, tag);
      tick;
      in_valid = 1'b0;
      tick;
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b1, 2'd0, 16'hFFFF, 32'h0000_1234, 6'd0, 8'h11);

      // Reset held two cycles with a valid beat presented
      tick;
      tick;
      checkOutput("rst_in_ready", 512'(in_ready), 512'(1'b0));
      checkOutput("rst_out_valid", 512'(out_valid), 512'(1'b0));
      checkOutput("rst_out_sig", 512'(out_sig), 512'(0));
      checkOutput("rst_out_shift", 512'(out_shift), 512'(0));
      checkOutput("rst_out_is_zero", 512'(out_is_zero), 512'(0));
      checkOutput("rst_out_mask", 512'(out_mask), 512'(0));
      checkOutput("rst_out_tag", 512'(out_tag), 512'(0));

      // First beat after reset: 0x1234 normalises by 19, latency 2
      reset = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", 512'(in_ready), 512'(1'b1));
      tick;
      in_valid = 1'b0;
      #1;
      checkOutput("lat1_out_valid", 512'(out_valid), 512'(1'b0));
      tick;
      #1;
      checkOutput("m0_1234_valid", 512'(out_valid), 512'(1'b1));
      checkOutput("m0_1234_shift", 512'(out_shift), 512'(expShift(6'd19, 16'hFFFF)));
      checkOutput("m0_1234_sig", 512'(out_sig), 512'(expSig(32'h91A0_0000, 16'hFFFF)));
      checkOutput("m0_1234_zero", 512'(out_is_zero), 512'(16'h0000));
      checkOutput("m0_1234_tag", 512'(out_tag), 512'(8'h11));
      checkOutput("m0_1234_mask", 512'(out_mask), 512'(16'hFFFF));

      // Mode 0, zero significand
      runBeat(2'd0, 32'h0000_0000, 6'd0, 8'h12);
      checkOutput("m0_zero_shift", 512'(out_shift), 512'(expShift(6'd32, 16'hFFFF)));
      checkOutput("m0_zero_sig", 512'(out_sig), 512'(0));
      checkOutput("m0_zero_flag", 512'(out_is_zero), 512'(16'hFFFF));

      // Mode 0, already normalised
      runBeat(2'd0, 32'h8000_0001, 6'd0, 8'h13);
      checkOutput("m0_msb_shift", 512'(out_shift), 512'(0));
      checkOutput("m0_msb_sig", 512'(out_sig), 512'(expSig(32'h8000_0001, 16'hFFFF)));

      // Mode 1, override 24
      runBeat(2'd1, 32'h0000_00FF, 6'd24, 8'h14);
      checkOutput("m1_24_sig", 512'(out_sig), 512'(expSig(32'hFF00_0000, 16'hFFFF)));
      checkOutput("m1_24_shift", 512'(out_shift), 512'(expShift(6'd24, 16'hFFFF)));
      checkOutput("m1_24_zero", 512'(out_is_zero), 512'(16'h0000));

      // Mode 1, override beyond the significand width
      runBeat(2'd1, 32'h0000_00FF, 6'd40, 8'h15);
      checkOutput("m1_40_sig", 512'(out_sig), 512'(0));
      checkOutput("m1_40_shift", 512'(out_shift), 512'(expShift(6'd40, 16'hFFFF)));
      checkOutput("m1_40_zero", 512'(out_is_zero), 512'(16'h0000));

      // Backpressure: six back-to-back pass-through beats, out_ready low in cycles 3..7
      tick;
      next_tag   = 1;
      exp_tag    = 1;
      stall_seen = 1'b0;
      prev_stall = 1'b0;
      held_tag   = '0;
      held_sig   = '0;
      for (int k = 0; k < 40 && exp_tag <= 6; k++) begin
         out_ready = !(k >= 3 && k <= 7);
         bp_val    = {4{8'(next_tag)}};
         if (next_tag <= 6) applyStimulus(1'b1, 2'd2, 16'hFFFF, bp_val, 6'd0, 8'(next_tag));
         else begin
            in_valid = 1'b0;
            #1;
         end
         if (in_valid && !in_ready) stall_seen = 1'b1;
         if (prev_stall) begin
            checkOutput("bp_hold_tag", 512'(out_tag), 512'(held_tag));
            checkOutput("bp_hold_sig", 512'(out_sig), 512'(held_sig));
         end
         if (out_valid && out_ready) begin
            checkOutput("bp_order_tag", 512'(out_tag), 512'(8'(exp_tag)));
            checkOutput("bp_data", 512'(out_sig), 512'(expSig({4{8'(exp_tag)}}, 16'hFFFF)));
            exp_tag++;
         end
         prev_stall = out_valid && !out_ready;
         held_tag   = out_tag;
         held_sig   = out_sig;
         do_in      = in_valid && in_ready;
         tick;
         if (do_in) next_tag++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_all_delivered", 512'(exp_tag), 512'(7));
      checkOutput("bp_in_ready_dropped", 512'(stall_seen), 512'(1'b1));

      // Mask 0x00FF with alternating mode 0 / mode 2 beats
      tick;
      for (int k = 0; k < 6; k++) begin
         mix_mode = (k % 2 == 0) ? 2'd0 : 2'd2;
         if (k < 4) applyStimulus(1'b1, mix_mode, 16'h00FF, 32'h0000_1234, 6'd0, 8'(8'h20 + k));
         else begin
            in_valid = 1'b0;
            #1;
         end
         if (k >= 2) begin
            checkOutput("mix_valid", 512'(out_valid), 512'(1'b1));
            checkOutput("mix_tag", 512'(out_tag), 512'(8'(8'h20 + k - 2)));
            checkOutput("mix_mask", 512'(out_mask), 512'(16'h00FF));
            checkOutput("mix_zero", 512'(out_is_zero), 512'(16'h0000));
            if ((k - 2) % 2 == 0) begin
               checkOutput("mix_m0_sig", 512'(out_sig), 512'(expSig(32'h91A0_0000, 16'h00FF)));
               checkOutput("mix_m0_shift", 512'(out_shift), 512'(expShift(6'd19, 16'h00FF)));
            end else begin
               checkOutput("mix_m2_sig", 512'(out_sig), 512'(expSig(32'h0000_1234, 16'h00FF)));
               checkOutput("mix_m2_shift", 512'(out_shift), 512'(0));
            end
         end
         tick;
      end

      // Reset mid-flight with two beats held in the pipe
      out_ready = 1'b0;
      applyStimulus(1'b1, 2'd2, 16'hFFFF, 32'hA1A1_A1A1, 6'd0, 8'hA1);
      tick;
      applyStimulus(1'b1, 2'd2, 16'hFFFF, 32'hA2A2_A2A2, 6'd0, 8'hA2);
      tick;
      checkOutput("mf_loaded_valid", 512'(out_valid), 512'(1'b1));
      in_valid = 1'b0;
      reset    = 1'b1;
      tick;
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      checkOutput("mf_out_valid_after_rst", 512'(out_valid), 512'(1'b0));
      for (int k = 0; k < 4; k++) begin
         tick;
         checkOutput("mf_no_ghost_beat", 512'(out_valid), 512'(1'b0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
